matrix_operand_fetcher: RTL and testbench
=========================================

Name: matrix_operand_fetcher

Overview:
- Upstream stage of the matrix multiplier.
- Given base addresses of two row-major N x N matrices A and B, it reads elements from a single-port, 1-cycle-latency data memory.
- It streams the operand pairs (A[i][k], B[k][j]) to the multiply datapath over a valid/ready handshake, in dot-product order.
- It flags the first and last pair of each dot product so the downstream multiply-accumulate can clear and emit C[i][j].

Parameters:
N, 4, matrix dimension; 2 to 16
DATA_W, 16, element width
ADDR_W, 16, word-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a full matrix pass
matrix_a_address  in  ADDR_W  base word address of A; sampled on accepted start
matrix_b_address  in  ADDR_W  base word address of B; sampled on accepted start
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en
op_valid  out  1  operand pair valid
op_ready  in  1  downstream accepts pair
op_a  out  DATA_W  A[i][k]
op_b  out  DATA_W  B[k][j]
op_first  out  1  k == 0
op_last  out  1  k == N-1
op_row  out  4  i
op_col  out  4  j
busy  out  1  pass in progress
done  out  1  one-cycle pulse after final pair accepted

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; all counters 0.
  - op_valid, mem_rd_en, busy, done = 0.
  - op_a, op_b, mem_addr, op_row, op_col = 0; op_first = op_last = 0.
- Iteration order: i outer, j middle, k inner, each 0..N-1. Total pairs per pass: N^3.
- Addresses:
  - A address = base_a + i*N + k; B address = base_b + k*N + j.
  - Formed with running offset registers; no multiplier.
  - Modulo 2^ADDR_W; wrap past 0xFFFF is silent and legal.
- FSM states: IDLE, RD_A, RD_B, CAPT, OUT, DONE.
  - IDLE: start=1 latches both bases, clears i/j/k, goes to RD_A; busy=1 from the next cycle. With start=0, stays.
  - RD_A: mem_rd_en=1, mem_addr = A address; goes to RD_B.
  - RD_B: mem_rd_en=1, mem_addr = B address; goes to CAPT.
  - CAPT: op_a <= mem_rdata (A data); mem_rd_en=0; goes to OUT.
  - OUT: op_b captured from mem_rdata on entry; op_valid=1.
    - Holds op_a, op_b, op_first, op_last, op_row, op_col stable until op_ready.
    - On op_valid && op_ready: advance k; on k wrap advance j; on j wrap advance i.
    - If that was the last pair (i = j = k = N-1), go to DONE; else go to RD_A.
    - op_valid drops the cycle after acceptance.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- mem_rd_en and mem_addr are Moore outputs decoded from registered state. mem_addr holds its last value when mem_rd_en=0.
- Latency:
  - First op_valid rises 3 cycles after the edge that samples start.
  - Steady state: 4 cycles per pair with op_ready held high.
  - done rises the cycle after the final acceptance.
- Boundaries:
  - start while busy: ignored; bases are not re-sampled.
  - op_ready high outside OUT: ignored.
  - op_ready low: indefinite stall in OUT; no memory reads issued.
  - start on the DONE cycle: ignored; it must be reasserted in IDLE.
  - Reset mid-pass: immediate return to IDLE; no done pulse; partial stream abandoned.
  - Rows/columns of width 4 cover N up to 16.

Test Plan:
- N=2, A at 0x0010 = {1,2,3,4}, B at 0x0020 = {5,6,7,8}, op_ready=1 → pairs in order:
  - (1,5)f, (2,7)l
  - (1,6)f, (2,8)l
  - (3,5)f, (4,7)l
  - (3,6)f, (4,8)l
  - row/col 00, 00, 01, 01, 10, 10, 11, 11; done one cycle after the 8th acceptance; first mem_addr = 0x0010 then 0x0020.
- Same setup, op_ready low for 5 cycles on the 3rd pair → op_a=1, op_b=6 held stable, mem_rd_en=0 throughout the stall; the remaining sequence is unchanged.
- Wrap: base_a = 0xFFFE, N=2 → A reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001 at the expected points.
- Second start pulsed while busy with different bases → ignored; the stream uses the original bases; the pair count stays 8.
- reset low during the 5th pair's RD_B → all outputs 0 asynchronously; after release, a new start with N=2 produces the full 8-pair stream from the start.
- N=4 random matrices, random op_ready → scoreboard: 64 pairs, exactly 16 op_first and 16 op_last, one done pulse, busy low only in IDLE.

Source files
------------

// File: rtl/matrix_operand_fetcher.sv
// Operand fetcher for the matrix multiplier. Reads A[i][k] and B[k][j] from a
// 1-cycle-latency memory and streams the pairs in dot-product order.
module matrix_operand_fetcher #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] matrix_a_address,
  input  logic [ADDR_W-1:0] matrix_b_address,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_first,
  output logic              op_last,
  output logic [3:0]        op_row,
  output logic [3:0]        op_col,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  // Handshake: a pair transfers on any rising edge where op_valid && op_ready;
  // op_valid stays high and the pair stays stable until then.
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAPT, OUT, DONE} state_t;

  localparam logic [3:0]        LAST   = 4'(N - 1);
  localparam logic [ADDR_W-1:0] N_STEP = ADDR_W'(N);

  state_t              state_q, state_d;
  logic [3:0]          i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0]   base_b_q, base_b_d;
  logic [ADDR_W-1:0]   a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0]   b_col_q, b_col_d, b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic                op_first_q, op_first_d, op_last_q, op_last_d;
  logic [3:0]          op_row_q, op_row_d, op_col_q, op_col_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      base_b_q    <= '0;
      a_row_q     <= '0;
      a_ptr_q     <= '0;
      b_col_q     <= '0;
      b_ptr_q     <= '0;
      last_addr_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_first_q  <= 1'b0;
      op_last_q   <= 1'b0;
      op_row_q    <= '0;
      op_col_q    <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      base_b_q    <= base_b_d;
      a_row_q     <= a_row_d;
      a_ptr_q     <= a_ptr_d;
      b_col_q     <= b_col_d;
      b_ptr_q     <= b_ptr_d;
      last_addr_q <= last_addr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_first_q  <= op_first_d;
      op_last_q   <= op_last_d;
      op_row_q    <= op_row_d;
      op_col_q    <= op_col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    base_b_d   = base_b_q;
    a_row_d    = a_row_q;
    a_ptr_d    = a_ptr_q;
    b_col_d    = b_col_q;
    b_ptr_d    = b_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_first_d = op_first_q;
    op_last_d  = op_last_q;
    op_row_d   = op_row_q;
    op_col_d   = op_col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_b_d = matrix_b_address;
          a_row_d  = matrix_a_address;
          a_ptr_d  = matrix_a_address;
          b_col_d  = matrix_b_address;
          b_ptr_d  = matrix_b_address;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          state_d  = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        // mem_rdata carries the A element during RD_B; it lands in op_a as CAPT begins.
        op_a_d     = mem_rdata;
        op_first_d = (k_q == 4'd0);
        op_last_d  = (k_q == LAST);
        op_row_d   = i_q;
        op_col_d   = j_q;
        state_d    = CAPT;
      end
      CAPT: begin
        op_b_d  = mem_rdata;
        state_d = OUT;
      end
      OUT: begin
        if (op_ready) begin
          state_d = (i_q == LAST && j_q == LAST && k_q == LAST) ? DONE : RD_A;
          if (k_q != LAST) begin
            k_d     = k_q + 4'd1;
            a_ptr_d = a_ptr_q + 1'b1;
            b_ptr_d = b_ptr_q + N_STEP;
          end else if (j_q != LAST) begin
            k_d     = '0;
            j_d     = j_q + 4'd1;
            a_ptr_d = a_row_q;
            b_col_d = b_col_q + 1'b1;
            b_ptr_d = b_col_q + 1'b1;
          end else begin
            k_d     = '0;
            j_d     = '0;
            i_d     = (i_q == LAST) ? 4'd0 : i_q + 4'd1;
            a_row_d = a_row_q + N_STEP;
            a_ptr_d = a_row_q + N_STEP;
            b_col_d = base_b_q;
            b_ptr_d = base_b_q;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address mux holds the previous address whenever no read is issued.
  always_comb begin
    mem_addr = last_addr_q;
    if (state_q == RD_A) mem_addr = a_ptr_q;
    if (state_q == RD_B) mem_addr = b_ptr_q;
    last_addr_d = mem_addr;
  end

  assign mem_rd_en = (state_q == RD_A) || (state_q == RD_B);
  assign op_valid  = (state_q == OUT);
  assign busy      = (state_q == RD_A) || (state_q == RD_B) ||
                     (state_q == CAPT) || (state_q == OUT);
  assign done      = (state_q == DONE);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_first  = op_first_q;
  assign op_last   = op_last_q;
  assign op_row    = op_row_q;
  assign op_col    = op_col_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_matrix_operand_fetcher.sv
// Directed bench for matrix_operand_fetcher: N=2 instance for the hand-computed
// streams and edge cases, N=4 instance for a longer randomised-handshake pass.
module tb_matrix_operand_fetcher;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=2 instance ----------------
  logic        start = 1'b0;
  logic [15:0] base_a = '0, base_b = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr, mem_rdata;
  logic        op_valid, op_ready = 1'b0;
  logic [15:0] op_a, op_b;
  logic        op_first, op_last;
  logic [3:0]  op_row, op_col;
  logic        busy, done;
  logic [2:0]  state_dbg;

  matrix_operand_fetcher #(.N(2), .DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .matrix_a_address(base_a), .matrix_b_address(base_b),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_first(op_first), .op_last(op_last), .op_row(op_row), .op_col(op_col),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- N=4 instance ----------------
  logic        start4 = 1'b0;
  logic [15:0] base_a4 = '0, base_b4 = '0;
  logic        mem_rd_en4;
  logic [15:0] mem_addr4, mem_rdata4;
  logic        op_valid4, op_ready4 = 1'b0;
  logic [15:0] op_a4, op_b4;
  logic        op_first4, op_last4;
  logic [3:0]  op_row4, op_col4;
  logic        busy4, done4;
  logic [2:0]  state_dbg4;

  matrix_operand_fetcher #(.N(4), .DATA_W(16), .ADDR_W(16)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .matrix_a_address(base_a4), .matrix_b_address(base_b4),
    .mem_rd_en(mem_rd_en4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
    .op_valid(op_valid4), .op_ready(op_ready4), .op_a(op_a4), .op_b(op_b4),
    .op_first(op_first4), .op_last(op_last4), .op_row(op_row4), .op_col(op_col4),
    .busy(busy4), .done(done4), .state_dbg(state_dbg4)
  );

  // Shared backing store, one read port per instance, 1-cycle latency.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rdata  <= mem[mem_addr];
    if (mem_rd_en4) mem_rdata4 <= mem[mem_addr4];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_errors = 0;
  logic [41:0] exp_q[$];
  logic [41:0] exp4_q[$];
  logic [15:0] rd_log[$];
  int cyc = 0, last_acc = 0, pair_cnt = 0, done_cnt = 0;
  int pairs4 = 0, first4 = 0, last4 = 0, done4_cnt = 0, busy_bad = 0;
  bit run4 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] pk(int a, int b, bit f, bit l, int r, int c);
    return {16'(a), 16'(b), f, l, 4'(r), 4'(c)};
  endfunction

  function automatic logic [15:0] log_at(int idx);
    return (rd_log.size() > idx) ? rd_log[idx] : 16'hDEAD;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (op_valid && op_ready) begin
        pair_cnt++;
        last_acc = cyc;
        if (exp_q.size() > 0)
          check("pair", 64'({op_a, op_b, op_first, op_last, op_row, op_col}), 64'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        check("done_lat", 64'(cyc - last_acc), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
      end
      if (mem_rd_en) rd_log.push_back(mem_addr);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (op_valid4 && op_ready4) begin
        pairs4++;
        first4 += 32'(op_first4);
        last4  += 32'(op_last4);
        if (exp4_q.size() > 0)
          check("pair4", 64'({op_a4, op_b4, op_first4, op_last4, op_row4, op_col4}), 64'(exp4_q.pop_front()));
      end
      if (done4) begin
        done4_cnt++;
        if (busy4) busy_bad++;
      end else if (run4 && done4_cnt == 0 && !busy4) busy_bad++;
      else if (run4 && done4_cnt > 0 && busy4) busy_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] ba, input logic [15:0] bb);
    tick();
    start = 1'b1; base_a = ba; base_b = bb;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int b = 0;
    while (done_cnt < target && b < 400) begin tick(); b++; end
    check(tag, 64'(done_cnt), 64'(target));
  endtask

  task automatic clear_logs();
    exp_q.delete();
    rd_log.delete();
    pair_cnt = 0;
  endtask

  task automatic push_t1();
    exp_q.push_back(pk(1, 5, 1, 0, 0, 0)); exp_q.push_back(pk(2, 7, 0, 1, 0, 0));
    exp_q.push_back(pk(1, 6, 1, 0, 0, 1)); exp_q.push_back(pk(2, 8, 0, 1, 0, 1));
    exp_q.push_back(pk(3, 5, 1, 0, 1, 0)); exp_q.push_back(pk(4, 7, 0, 1, 1, 0));
    exp_q.push_back(pk(3, 6, 1, 0, 1, 1)); exp_q.push_back(pk(4, 8, 0, 1, 1, 1));
  endtask

  task automatic push_model(input int n, input logic [15:0] ba, input logic [15:0] bb, input bit to4);
    logic [41:0] e;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int k = 0; k < n; k++) begin
          e = pk(int'(mem[16'(ba + i*n + k)]), int'(mem[16'(bb + k*n + j)]),
                 k == 0, k == n-1, i, j);
          if (to4) exp4_q.push_back(e);
          else     exp_q.push_back(e);
        end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, b;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + i] = 16'(i + 1);
      mem[16'h0020 + i] = 16'(i + 5);
      mem[16'h0030 + i] = 16'(16'h0090 + i);
      mem[16'h0040 + i] = 16'(16'h00C0 + i);
      mem[16'h0100 + i] = 16'(16'h00B1 + i);
    end
    mem[16'hFFFE] = 16'h00A1; mem[16'hFFFF] = 16'h00A2;
    mem[16'h0000] = 16'h00A3; mem[16'h0001] = 16'h00A4;

    reset = 1'b0;
    repeat (3) tick();
    check("reset_outs", 64'({op_valid, mem_rd_en, busy, done, op_a, op_b, mem_addr,
                             op_row, op_col, op_first, op_last}), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(0));
    reset = 1'b1;
    tick();

    // Basic N=2 stream with latency and first addresses.
    clear_logs(); push_t1(); op_ready = 1'b1;
    do_start(16'h0010, 16'h0020);
    lat = 0;
    while (!op_valid && lat < 20) begin tick(); lat++; end
    check("first_valid_lat", 64'(lat), 64'(3));
    wait_done(1, "t1_done");
    check("t1_pairs", 64'(pair_cnt), 64'(8));
    check("t1_exp_left", 64'(exp_q.size()), 64'(0));
    check("t1_first_addrs", 64'({log_at(0), log_at(1)}), 64'({16'h0010, 16'h0020}));
    check("t1_reads", 64'(rd_log.size()), 64'(16));
    check("t1_idle", 64'({busy, done, op_valid, mem_rd_en}), 64'(0));

    // Stall on the third pair.
    clear_logs(); push_t1(); op_ready = 1'b1;
    do_start(16'h0010, 16'h0020);
    b = 0;
    while (pair_cnt < 2 && b < 100) begin tick(); b++; end
    op_ready = 1'b0;
    b = 0;
    while (!op_valid && b < 20) begin tick(); b++; end
    for (int s = 0; s < 5; s++) begin
      check("stall_a", 64'(op_a), 64'(1));
      check("stall_b", 64'(op_b), 64'(6));
      check("stall_rd", 64'(mem_rd_en), 64'(0));
      check("stall_valid", 64'(op_valid), 64'(1));
      check("stall_tag", 64'({op_first, op_last, op_row, op_col}), 64'({1'b1, 1'b0, 4'd0, 4'd1}));
      tick();
    end
    op_ready = 1'b1;
    wait_done(2, "t2_done");
    check("t2_pairs", 64'(pair_cnt), 64'(8));
    check("t2_exp_left", 64'(exp_q.size()), 64'(0));
    check("t2_reads", 64'(rd_log.size()), 64'(16));

    // Address wrap past 0xFFFF.
    clear_logs(); push_model(2, 16'hFFFE, 16'h0100, 1'b0);
    do_start(16'hFFFE, 16'h0100);
    wait_done(3, "t3_done");
    check("t3_pairs", 64'(pair_cnt), 64'(8));
    check("t3_exp_left", 64'(exp_q.size()), 64'(0));
    check("wrap_addrs", 64'({log_at(0), log_at(2), log_at(8), log_at(10)}),
          64'({16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}));

    // Start while busy is ignored.
    clear_logs(); push_t1();
    do_start(16'h0010, 16'h0020);
    tick(); tick();
    start = 1'b1; base_a = 16'h0030; base_b = 16'h0040;
    tick();
    start = 1'b0;
    wait_done(4, "t4_done");
    check("t4_pairs", 64'(pair_cnt), 64'(8));
    check("t4_exp_left", 64'(exp_q.size()), 64'(0));
    check("t4_b_base", 64'(log_at(1)), 64'(16'h0020));

    // Asynchronous reset during the fifth pair's B read.
    clear_logs(); push_t1();
    do_start(16'h0010, 16'h0020);
    b = 0;
    while (pair_cnt < 4 && b < 100) begin tick(); b++; end
    tick();
    check("p5_rdb", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 16'h0020}));
    #2 reset = 1'b0;
    #1;
    check("async_reset", 64'({op_valid, mem_rd_en, busy, done, op_a, op_b, mem_addr,
                              op_row, op_col, op_first, op_last}), 64'(0));
    repeat (3) tick();
    check("no_done_after_reset", 64'(done_cnt), 64'(4));
    reset = 1'b1;
    tick();
    clear_logs(); push_t1();
    do_start(16'h0010, 16'h0020);
    wait_done(5, "t5_done");
    check("t5_pairs", 64'(pair_cnt), 64'(8));
    check("t5_exp_left", 64'(exp_q.size()), 64'(0));
    check("t5_first_addr", 64'(log_at(0)), 64'(16'h0010));

    // N=4 random data, random op_ready.
    for (int i = 0; i < 16; i++) begin
      mem[16'h0200 + i] = 16'($urandom_range(0, 65535));
      mem[16'h0300 + i] = 16'($urandom_range(0, 65535));
    end
    exp4_q.delete();
    push_model(4, 16'h0200, 16'h0300, 1'b1);
    tick();
    start4 = 1'b1; base_a4 = 16'h0200; base_b4 = 16'h0300;
    tick();
    start4 = 1'b0;
    run4 = 1'b1;
    b = 0;
    while (done4_cnt < 1 && b < 3000) begin
      op_ready4 = 1'($urandom_range(0, 1));
      tick();
      b++;
    end
    check("n4_done_seen", 64'(done4_cnt), 64'(1));
    repeat (5) tick();
    check("n4_done_once", 64'(done4_cnt), 64'(1));
    check("n4_pairs", 64'(pairs4), 64'(64));
    check("n4_first", 64'(first4), 64'(16));
    check("n4_last", 64'(last4), 64'(16));
    check("n4_busy", 64'(busy_bad), 64'(0));
    check("n4_exp_left", 64'(exp4_q.size()), 64'(0));
    run4 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
